dds_sweep_ctrl: RTL and testbench

Frequency-sweep sequencer for the DDS datapath. Latches a sweep configuration on a start pulse, then drives the DDS phase accumulator's frequency tuning word (FTW) through a linear ramp from `f_start` to `f_stop` in `f_step` increments, holding each point for a programmable dwell. Sits between the PS-side control registers and the DDS core. The core's 8-bit output continues through the DA output stage unchanged.

---
 rtl/dds_pkg.sv | 22 ++
 rtl/dds_sweep_step.sv | 37 +++
 rtl/dds_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: sweep FSM states, default widths and the tuning
// word type used by both the sweep controller and the DDS core.
// The DOWN state only exists when DDS_SWEEP_TRIANGLE_EN is defined.
package dds_pkg;

  localparam int FTW_W   = 32;
  localparam int DWELL_W = 16;

  typedef logic [FTW_W-1:0] ftw_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DWELL,
    ST_STEP,
    ST_FIN
`ifdef DDS_SWEEP_TRIANGLE_EN
    , ST_DOWN
`endif
  } state_e;

endpackage

// File: rtl/dds_sweep_step.sv
// One sweep step: saturating add (DOWN=0) or subtract (DOWN=1) of the step
// size, clamped to a limit, with a flag marking the clamped point as last.
// Arithmetic is one bit wider so a carry or borrow counts as crossing the limit.
module dds_sweep_step
  import dds_pkg::*;
#(
  parameter int W    = FTW_W,
  parameter bit DOWN = 1'b0
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] nxt,
  output logic         last
);

  logic [W:0] acc;

  generate
    if (DOWN) begin : g_down
      // A borrow means we went below zero, which is below any limit
      always_comb begin
        acc  = {1'b0, cur} - {1'b0, step};
        last = acc[W] || (acc[W-1:0] <= limit);
      end
    end else begin : g_up
      // A carry means we went past the top of the range, above any limit
      always_comb begin
        acc  = {1'b0, cur} + {1'b0, step};
        last = (acc >= {1'b0, limit});
      end
    end
  endgenerate

  assign nxt = last ? limit : acc[W-1:0];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: latches a sweep configuration on start and walks
// the DDS tuning word from f_start to f_stop in f_step increments, holding
// each point for max(dwell,1)+1 cycles. All outputs are registered.
// Define DDS_SWEEP_TRIANGLE_EN to add a DOWN phase back to f_start.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FTW_W   = dds_pkg::FTW_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic               clk_dds,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [FTW_W-1:0]   f_start,
  input  logic [FTW_W-1:0]   f_stop,
  input  logic [FTW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_vld,
  output logic               phase_rst,
  output logic               busy,
  output logic               done
);

  state_e               state;

  // Configuration captured at start; the live inputs may change mid-sweep
  logic [FTW_W-1:0]     sh_start;
  logic [FTW_W-1:0]     sh_stop;
  logic [FTW_W-1:0]     sh_step;
  logic [DWELL_W-1:0]   sh_dwell;

  logic [DWELL_W-1:0]   cnt;
  logic [DWELL_W-1:0]   reload;
  logic                 last_pt;
  logic                 degen;

  logic [FTW_W-1:0]     up_nxt;
  logic                 up_last;

`ifdef DDS_SWEEP_TRIANGLE_EN
  logic                 down_ph;
  logic [FTW_W-1:0]     dn_nxt;
  logic                 dn_last;
`endif

  // A dwell of zero still holds each point for one dwell cycle
  assign reload = (sh_dwell == '0) ? DWELL_W'(1) : sh_dwell;

  // Zero step or an empty/inverted range collapses to the single point f_start
  assign degen  = (sh_step == '0) || (sh_start >= sh_stop);

  dds_sweep_step #(
    .W    (FTW_W),
    .DOWN (1'b0)
  ) u_up (
    .cur   (ftw),
    .step  (sh_step),
    .limit (sh_stop),
    .nxt   (up_nxt),
    .last  (up_last)
  );

`ifdef DDS_SWEEP_TRIANGLE_EN
  dds_sweep_step #(
    .W    (FTW_W),
    .DOWN (1'b1)
  ) u_dn (
    .cur   (ftw),
    .step  (sh_step),
    .limit (sh_start),
    .nxt   (dn_nxt),
    .last  (dn_last)
  );
`endif

  // Sweep FSM with shadow registers, dwell counter and registered outputs
  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      cnt       <= '0;
      last_pt   <= 1'b0;
      ftw       <= '0;
      ftw_vld   <= 1'b0;
      phase_rst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
      down_ph   <= 1'b0;
`endif
    end else begin
      ftw_vld   <= 1'b0;
      phase_rst <= 1'b0;
      done      <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        // Stop where we are: ftw keeps its value, no done
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              sh_start <= f_start;
              sh_stop  <= f_stop;
              sh_step  <= f_step;
              sh_dwell <= dwell;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            ftw       <= sh_start;
            ftw_vld   <= 1'b1;
            phase_rst <= 1'b1;
            busy      <= 1'b1;
            cnt       <= reload;
            last_pt   <= degen;
`ifdef DDS_SWEEP_TRIANGLE_EN
            // A single-point sweep has no turnaround, treat it as already down
            down_ph   <= degen;
`endif
            state     <= ST_DWELL;
          end
          ST_DWELL: begin
            cnt <= cnt - DWELL_W'(1);
            if (cnt == DWELL_W'(1)) begin
              if (last_pt) begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                if (!down_ph) begin
                  state <= ST_DOWN;
                end else begin
                  state <= ST_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
`else
                state <= ST_FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
`endif
              end else begin
`ifdef DDS_SWEEP_TRIANGLE_EN
                state <= down_ph ? ST_DOWN : ST_STEP;
`else
                state <= ST_STEP;
`endif
              end
            end
          end
          ST_STEP: begin
            ftw     <= up_nxt;
            last_pt <= up_last;
            ftw_vld <= 1'b1;
            cnt     <= reload;
            state   <= ST_DWELL;
          end
`ifdef DDS_SWEEP_TRIANGLE_EN
          ST_DOWN: begin
            ftw     <= dn_nxt;
            last_pt <= dn_last;
            down_ph <= 1'b1;
            ftw_vld <= 1'b1;
            cnt     <= reload;
            state   <= ST_DWELL;
          end
`endif
          ST_FIN: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. A reference model turns each sweep
// configuration into its list of frequency points, then into a per-cycle
// table of expected {ftw, ftw_vld, phase_rst, busy, done}.
module tb_dds_sweep_ctrl;

  logic        clk_dds = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [15:0] dwell;
  logic [31:0] ftw;
  logic        ftw_vld;
  logic        phase_rst;
  logic        busy;
  logic        done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cur_ftw;
  logic [35:0] tr[$];

  dds_sweep_ctrl dut (
    .clk_dds   (clk_dds),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .ftw       (ftw),
    .ftw_vld   (ftw_vld),
    .phase_rst (phase_rst),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_dds = ~clk_dds;

  function automatic logic [35:0] obs();
    return {ftw, ftw_vld, phase_rst, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Expected per-cycle trace, starting with the LOAD cycle
  task automatic build(input logic [31:0] s, input logic [31:0] e,
                       input logic [31:0] st, input logic [15:0] dw);
    longint pts[$];
    longint p;
    int     d;
    logic   fin;
    tr.delete();
    d = (dw == 16'd0) ? 1 : int'(dw);
    pts.push_back(longint'(s));
    if (st != 32'd0 && s < e) begin
      p = longint'(s);
      do begin
        p += longint'(st);
        pts.push_back((p >= longint'(e)) ? longint'(e) : p);
      end while (p < longint'(e));
`ifdef DDS_SWEEP_TRIANGLE_EN
      p = longint'(e);
      do begin
        p -= longint'(st);
        pts.push_back((p <= longint'(s)) ? longint'(s) : p);
      end while (p > longint'(s));
`endif
    end
    tr.push_back({cur_ftw, 4'b0000});
    foreach (pts[i]) begin
      for (int c = 0; c <= d; c++) begin
        fin = (i == pts.size() - 1) && (c == d);
        tr.push_back({32'(pts[i]), (c == 0), (i == 0 && c == 0), !fin, fin});
      end
    end
  endtask

  // ab_at/bs_at: -1 none, -2 random index; rs_at: -1 none
  task automatic run(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                     input logic [15:0] dw, input int ab_at, input int bs_at, input int rs_at);
    int a;
    int b;
    build(s, e, st, dw);
    a = (ab_at == -2) ? int'($urandom_range(0, tr.size() - 1)) : ab_at;
    b = (bs_at == -2) ? int'($urandom_range(0, tr.size() - 1)) : bs_at;
    @(negedge clk_dds);
    f_start = s; f_stop = e; f_step = st; dwell = dw; start = 1'b1;
    for (int i = 0; i < tr.size(); i++) begin
      @(negedge clk_dds);
      start = 1'b0; abort = 1'b0;
      // Live inputs are scrambled to prove the shadow copy is used
      f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'($urandom);
      chk($sformatf("cyc%0d", i), {28'b0, obs()}, {28'b0, tr[i]});
      cur_ftw = tr[i][35:4];
      if (i == rs_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async", {28'b0, obs()}, 64'd0);
        cur_ftw = '0;
        @(negedge clk_dds);
        rst = 1'b0;
        break;
      end
      if (i == a) begin
        abort = 1'b1;
        break;
      end
      if (i == b) start = 1'b1;
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_dds);
      start = 1'b0; abort = 1'b0;
      chk($sformatf("idle%0d", j), {28'b0, obs()}, {28'b0, cur_ftw, 4'b0000});
    end
  endtask

  task automatic start_abort_idle();
    @(negedge clk_dds);
    f_start = 32'd100; f_stop = 32'd130; f_step = 32'd10; dwell = 16'd3;
    start = 1'b1; abort = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_dds);
      start = 1'b0; abort = 1'b0;
      chk($sformatf("sa_idle%0d", j), {28'b0, obs()}, {28'b0, cur_ftw, 4'b0000});
    end
  endtask

  initial begin
    logic [31:0] s, e, st;
    logic [15:0] dw;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    cur_ftw = '0;
    repeat (2) @(negedge clk_dds);
    chk("reset", {28'b0, obs()}, 64'd0);
    rst = 1'b0;

    run(32'd100, 32'd130, 32'd10, 16'd3, -1, -1, -1);
    run(32'd0, 32'd25, 32'd10, 16'd2, -1, -1, -1);
    run(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, -1, -1, -1);
    run(32'd77, 32'd200, 32'd0, 16'd0, -1, -1, -1);
    run(32'd50, 32'd40, 32'd5, 16'd0, -1, -1, -1);
    run(32'd60, 32'd60, 32'd7, 16'd2, -1, -1, -1);
    run(32'd100, 32'd130, 32'd10, 16'd3, 6, -1, -1);
    run(32'd100, 32'd130, 32'd10, 16'd3, -1, 3, -1);
    start_abort_idle();
    run(32'd100, 32'd130, 32'd10, 16'd3, -1, -1, 4);
    run(32'd100, 32'd130, 32'd10, 16'd3, -1, -1, -1);
    run(32'd0, 32'd10, 32'd3, 16'd7, -1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        s = 32'hFFFF_FF00 + $urandom_range(0, 255);
        e = 32'hFFFF_FF00 + $urandom_range(0, 255);
      end else begin
        s = $urandom_range(0, 120);
        e = $urandom_range(0, 120);
      end
      st = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      dw = 16'($urandom_range(0, 4));
      run(s, e, st, dw,
          ($urandom_range(0, 3) == 0) ? -2 : -1,
          ($urandom_range(0, 2) == 0) ? -2 : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
